// File: rtl/up_pkg.sv
// up_pkg: definitions shared by the micro-processor interrupt logic.
//   int_state_t      request FSM states (IDLE, REQ)
//   VEC_BASE_DEFAULT vector of interrupt channel 0
//   OP_GIE_TOGGLE    opcode whose execute cycle pulses gie_toggle
//   OP_RETURN        return opcode; its execute cycle pulses eoi
//   id_width()       width of a channel index for n channels (never 0)
package up_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } int_state_t;

  localparam logic [7:0] VEC_BASE_DEFAULT = 8'hF0;
  localparam logic [3:0] OP_GIE_TOGGLE    = 4'hF;
  localparam logic [3:0] OP_RETURN        = 4'hE;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/up_int_prio_enc.sv
// up_int_prio_enc: fixed-priority encoder, lowest set index wins.
//   req    in   N     request bits, bit 0 = highest priority
//   idx    out  W     index of the lowest set bit (0 when none set)
//   valid  out  1     at least one request bit is set
module up_int_prio_enc
  import up_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = id_width(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    idx   = '0;
    valid = |req;
    // Scan from the top down so the lowest set index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/up_int_ctrl.sv
// up_int_ctrl: vectored interrupt controller for the micro-processor core.
// Collects N_INT edge/level lines into a pending register, filters them by
// mask, global enable and in-service priority, and offers one registered
// request (channel id + vector) to the controller FSM. Accepted channels are
// tracked as in service until retired by end-of-interrupt.
//   clk         in   1       clock, rising edge
//   nRst        in   1       asynchronous active-low reset
//   int_in      in   N_INT   raw interrupt lines, synchronous to clk
//   gie_toggle  in   1       pulse: invert global enable
//   mask_we     in   1       load mask from mask_wd (1 = masked)
//   mask_wd     in   N_INT
//   mode_we     in   1       load mode from mode_wd (1 = level, 0 = edge)
//   mode_wd     in   N_INT
//   irq_ack     in   1       controller accepts the current request
//   eoi         in   1       retire highest-priority in-service channel
//   irq_req     out  1       registered request
//   irq_id      out  ID_W    winning channel, stable while irq_req
//   irq_vec     out  VEC_W   VEC_BASE + irq_id, stable while irq_req
//   pending     out  N_INT   pending register
//   in_service  out  N_INT   in-service register
//   gie         out  1       global interrupt enable
module up_int_ctrl
  import up_pkg::*;
#(
  parameter  int               N_INT    = 4,
  parameter  int               VEC_W    = 8,
  parameter  logic [VEC_W-1:0] VEC_BASE = VEC_W'(VEC_BASE_DEFAULT),
  parameter  int               NEST     = 1,
  localparam int               ID_W     = id_width(N_INT)
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [N_INT-1:0] int_in,
  input  logic             gie_toggle,
  input  logic             mask_we,
  input  logic [N_INT-1:0] mask_wd,
  input  logic             mode_we,
  input  logic [N_INT-1:0] mode_wd,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [VEC_W-1:0] irq_vec,
  output logic [N_INT-1:0] pending,
  output logic [N_INT-1:0] in_service,
  output logic             gie
);

  int_state_t       state;
  logic [N_INT-1:0] mask;
  logic [N_INT-1:0] mode;
  logic [N_INT-1:0] int_last;

  logic [N_INT-1:0] edge_det;
  logic [N_INT-1:0] prio_ok;
  logic [N_INT-1:0] eligible;
  logic [N_INT-1:0] ack_set;
  logic [N_INT-1:0] eoi_clr;
  logic [N_INT-1:0] pend_next;
  logic [N_INT-1:0] is_next;

  logic             ack_fire;
  logic             arb_valid;
  logic [ID_W-1:0]  arb_id;
  logic             eoi_valid;
  logic [ID_W-1:0]  eoi_id;

  assign edge_det = int_in & ~int_last;
  assign ack_fire = (state == REQ) && irq_ack;

  // A channel may only be offered when no channel of equal or higher
  // priority is in service (nesting), or when nothing is in service at all.
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    prio_ok = '0;
    for (int k = 0; k < N_INT; k++) begin
      blocked    = blocked | in_service[k];
      prio_ok[k] = (NEST != 0) ? ~blocked : ~|in_service;
    end
  end

  assign eligible = pending & ~mask & ~in_service & prio_ok;

  up_int_prio_enc #(.N(N_INT)) u_arb_enc (
    .req   (eligible),
    .idx   (arb_id),
    .valid (arb_valid)
  );

  up_int_prio_enc #(.N(N_INT)) u_eoi_enc (
    .req   (in_service),
    .idx   (eoi_id),
    .valid (eoi_valid)
  );

  // The eoi clear is taken from the pre-ack in_service, then the ack's set
  // is merged in, so an ack and an eoi in the same cycle both land.
  always_comb begin
    ack_set = '0;
    eoi_clr = '0;
    if (ack_fire)          ack_set[irq_id] = 1'b1;
    if (eoi && eoi_valid)  eoi_clr[eoi_id] = 1'b1;
    is_next = (in_service & ~eoi_clr) | ack_set;
  end

  // Edge channels: a new edge wins over the ack clear in the same cycle.
  // Level channels follow the line but stay low while in service.
  // Changing a channel's mode discards whatever it had pending.
  always_comb begin
    pend_next = '0;
    for (int k = 0; k < N_INT; k++) begin
      if (mode_we && (mode_wd[k] != mode[k]))
        pend_next[k] = 1'b0;
      else if (mode[k])
        pend_next[k] = int_in[k] & ~in_service[k];
      else
        pend_next[k] = edge_det[k] | (pending[k] & ~ack_set[k]);
    end
  end

  // NOTE: every register, including the in-service bookkeeping, is cleared
  // by the asynchronous reset so a reset mid-service leaves no stale state.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      gie        <= 1'b0;
      mask       <= '0;
      mode       <= '0;
      int_last   <= '0;
      pending    <= '0;
      in_service <= '0;
      irq_req    <= 1'b0;
      irq_id     <= '0;
      irq_vec    <= VEC_BASE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      int_last   <= int_in;
      gie        <= gie ^ gie_toggle;
      pending    <= pend_next;
      in_service <= is_next;
      if (mask_we) mask <= mask_wd;
      if (mode_we) mode <= mode_wd;

      case (state)
        IDLE: begin
          if (gie && arb_valid) begin
            state   <= REQ;
            irq_req <= 1'b1;
            irq_id  <= arb_id;
            irq_vec <= VEC_BASE + VEC_W'(arb_id);
          end
        end
        REQ: begin
          // Id and vector are held; only ack or loss of eligibility leaves.
          if (irq_ack || !(gie && eligible[irq_id])) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_int_ctrl.sv
// tb_up_int_ctrl: directed bench for up_int_ctrl (N_INT=4, VEC_W=8,
// VEC_BASE=8'hF0, NEST=1). A cycle-level reference model tracks the
// controller's rules and is compared against the outputs on every falling
// edge; directed scenarios add literal expectations at fixed points.
module tb_up_int_ctrl;

  logic       clk;
  logic       nRst;
  logic [3:0] int_in;
  logic       gie_toggle;
  logic       mask_we;
  logic [3:0] mask_wd;
  logic       mode_we;
  logic [3:0] mode_wd;
  logic       irq_ack;
  logic       eoi;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [7:0] irq_vec;
  logic [3:0] pending;
  logic [3:0] in_service;
  logic       gie;

  int n_total = 0;
  int n_bad   = 0;

  up_int_ctrl #(
    .N_INT    (4),
    .VEC_W    (8),
    .VEC_BASE (8'hF0),
    .NEST     (1)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .int_in     (int_in),
    .gie_toggle (gie_toggle),
    .mask_we    (mask_we),
    .mask_wd    (mask_wd),
    .mode_we    (mode_we),
    .mode_wd    (mode_wd),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_vec    (irq_vec),
    .pending    (pending),
    .in_service (in_service),
    .gie        (gie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit       m_gie, m_req;
  bit [3:0] m_mask, m_mode, m_pend, m_isv, m_last;
  int       m_id;

  function automatic int first_set(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Channel k may be served if it is pending, unmasked, and no channel of
  // equal or higher priority (index <= k) is in service.
  function automatic bit may_serve(input int k, input bit [3:0] p,
                                   input bit [3:0] mk, input bit [3:0] isv);
    if (!p[k] || mk[k]) return 1'b0;
    for (int j = 0; j <= k; j++) if (isv[j]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge nRst) begin : model
    bit       ack;
    int       c;
    bit [3:0] isv_n, p_n;
    if (!nRst) begin
      m_gie = 0; m_req = 0; m_id = 0;
      m_mask = 0; m_mode = 0; m_pend = 0; m_isv = 0; m_last = 0;
    end else begin
      ack   = m_req && irq_ack;
      isv_n = m_isv;
      if (eoi) begin
        c = first_set(m_isv);
        if (c >= 0) isv_n[c] = 1'b0;
      end
      if (ack) isv_n[m_id] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (mode_we && (mode_wd[k] != m_mode[k])) p_n[k] = 1'b0;
        else if (m_mode[k]) p_n[k] = int_in[k] && !m_isv[k];
        else p_n[k] = (int_in[k] && !m_last[k]) || (m_pend[k] && !(ack && m_id == k));
      end
      if (m_req) begin
        if (ack || !(m_gie && may_serve(m_id, m_pend, m_mask, m_isv))) m_req = 1'b0;
      end else if (m_gie) begin
        for (int k = 0; k < 4; k++) begin
          if (!m_req && may_serve(k, m_pend, m_mask, m_isv)) begin
            m_req = 1'b1;
            m_id  = k;
          end
        end
      end
      m_pend = p_n;
      m_isv  = isv_n;
      m_last = int_in;
      m_gie  = m_gie ^ gie_toggle;
      if (mask_we) m_mask = mask_wd;
      if (mode_we) m_mode = mode_wd;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (nRst) begin
      check("cyc_req", 32'(irq_req), 32'(m_req));
      check("cyc_pending", 32'(pending), 32'(m_pend));
      check("cyc_in_service", 32'(in_service), 32'(m_isv));
      check("cyc_gie", 32'(gie), 32'(m_gie));
      if (m_req) begin
        check("cyc_id", 32'(irq_id), 32'(m_id));
        check("cyc_vec", 32'(irq_vec), 32'(8'hF0 + 8'(m_id)));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Advance n edges; pulse inputs are cleared 1 time unit after the edge.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
    gie_toggle = 0; mask_we = 0; mode_we = 0; irq_ack = 0; eoi = 0;
  endtask

  task automatic expect_req(input string name, input logic r, input logic [1:0] id);
    check({name, "_req"}, 32'(irq_req), 32'(r));
    if (r) begin
      check({name, "_id"}, 32'(irq_id), 32'(id));
      check({name, "_vec"}, 32'(irq_vec), 32'(8'hF0 + 8'(id)));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 0; int_in = 0; gie_toggle = 0; mask_we = 0; mask_wd = 0;
    mode_we = 0; mode_wd = 0; irq_ack = 0; eoi = 0;
    step(2);
    nRst = 1;
    step(1);
    check("rst_req", 32'(irq_req), 0);
    check("rst_vec", 32'(irq_vec), 32'h0F0);
    check("rst_gie", 32'(gie), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_in_service", 32'(in_service), 0);

    // S1: single edge on ch2, latency t -> t+1 pending -> t+2 request
    gie_toggle = 1; step();
    check("s1_gie", 32'(gie), 1);
    int_in = 4'b0100; step();
    check("s1_pending", 32'(pending), 32'b0100);
    expect_req("s1_early", 0, 0);
    step();
    expect_req("s1", 1, 2);
    irq_ack = 1; step();
    check("s1_isv", 32'(in_service), 32'b0100);
    check("s1_pend_clr", 32'(pending), 0);
    expect_req("s1_ack", 0, 0);
    eoi = 1; step();
    check("s1_eoi", 32'(in_service), 0);
    int_in = 0; step();

    // S2: simultaneous edges ch1 + ch3
    int_in = 4'b1010; step();
    check("s2_pending", 32'(pending), 32'b1010);
    step();
    expect_req("s2_first", 1, 1);
    irq_ack = 1; step();
    check("s2_isv", 32'(in_service), 32'b0010);
    check("s2_pend", 32'(pending), 32'b1000);
    step();
    expect_req("s2_blocked", 0, 0);
    eoi = 1; step();
    check("s2_eoi", 32'(in_service), 0);
    step();
    expect_req("s2_second", 1, 3);
    irq_ack = 1; step();
    eoi = 1; step();
    int_in = 0; step();

    // S3: nesting; same-cycle ack + eoi
    int_in = 4'b0100; step(2);
    expect_req("s3_ch2", 1, 2);
    irq_ack = 1; step();
    int_in = 4'b0101; step();
    check("s3_pend0", 32'(pending), 32'b0001);
    step();
    expect_req("s3_preempt", 1, 0);
    irq_ack = 1; eoi = 1; step();
    check("s3_ack_eoi", 32'(in_service), 32'b0001);
    int_in = 4'b1101; step();
    check("s3_pend3", 32'(pending), 32'b1000);
    step();
    expect_req("s3_ch3_blocked", 0, 0);
    eoi = 1; step();
    check("s3_eoi", 32'(in_service), 0);
    step();
    expect_req("s3_ch3", 1, 3);
    irq_ack = 1; step();
    eoi = 1; step();
    int_in = 0; step();

    // S4: level ch1, masking, mode change, re-request after eoi
    mask_we = 1; mask_wd = 4'b0010; mode_we = 1; mode_wd = 4'b0010; step();
    int_in = 4'b0010; step();
    check("s4_pend", 32'(pending), 32'b0010);
    step(2);
    expect_req("s4_masked", 0, 0);
    mode_we = 1; mode_wd = 4'b0000; step();
    check("s4_mode_clr", 32'(pending), 0);
    mode_we = 1; mode_wd = 4'b0010; step();
    check("s4_mode_clr2", 32'(pending), 0);
    step();
    check("s4_level_again", 32'(pending), 32'b0010);
    mask_we = 1; mask_wd = 4'b0000; step();
    expect_req("s4_unmask_edge", 0, 0);
    step();
    expect_req("s4_unmasked", 1, 1);
    irq_ack = 1; step();
    check("s4_isv", 32'(in_service), 32'b0010);
    check("s4_pend_kept", 32'(pending), 32'b0010);
    step();
    check("s4_pend_is", 32'(pending), 0);
    eoi = 1; step();
    check("s4_eoi", 32'(in_service), 0);
    step();
    check("s4_pend_back", 32'(pending), 32'b0010);
    expect_req("s4_wait", 0, 0);
    step();
    expect_req("s4_rereq", 1, 1);
    irq_ack = 1; step();
    int_in = 0; eoi = 1; step();
    step();
    mode_we = 1; mode_wd = 4'b0000; step();
    step();

    // S5: gie dropped while requesting
    int_in = 4'b0001; step(2);
    expect_req("s5_req", 1, 0);
    gie_toggle = 1; step();
    check("s5_gie_off", 32'(gie), 0);
    step();
    expect_req("s5_dropped", 0, 0);
    check("s5_pend_kept", 32'(pending), 32'b0001);
    gie_toggle = 1; step();
    step();
    expect_req("s5_rereq", 1, 0);
    irq_ack = 1; step();
    int_in = 0; eoi = 1; step();
    step();

    // S6: async reset while requesting with channels in service
    int_in = 4'b0100; step(2);
    irq_ack = 1; step();
    int_in = 4'b0110; step(2);
    expect_req("s6_ch1", 1, 1);
    irq_ack = 1; step();
    int_in = 4'b0111; step(2);
    expect_req("s6_ch0", 1, 0);
    check("s6_isv", 32'(in_service), 32'b0110);
    nRst = 0; int_in = 0;
    #1;
    check("s6_rst_req", 32'(irq_req), 0);
    check("s6_rst_id", 32'(irq_id), 0);
    check("s6_rst_vec", 32'(irq_vec), 32'h0F0);
    check("s6_rst_pend", 32'(pending), 0);
    check("s6_rst_isv", 32'(in_service), 0);
    check("s6_rst_gie", 32'(gie), 0);
    step();
    nRst = 1;
    step(3);
    expect_req("s6_after", 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
